m_mask_alu_engine: RTL and testbench

M_MASK_ALU_ENGINE -- requirements
Module: m_mask_alu_engine

---
 rtl/m_mask_alu_engine.sv | 170 +++++++++++++++++
 tb/tb_m_mask_alu_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/m_mask_alu_engine.sv
// Masked-operand accumulator engine: valid/ready instruction in, one result out.
// Executes LOAD/ADD/SUB/AND/MUL/CMP/STORE/ADDR on a 2*WORD accumulator.
module m_mask_alu_engine #(
  parameter  int WORD  = 8,
  parameter  int NREG  = 4,
  localparam int DWORD = 2 * WORD,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [RW-1:0]    sel,
  input  logic [WORD-1:0]  din,
  input  logic [WORD-1:0]  h_IMASK,
  input  logic [WORD-1:0]  h_PMASK,
  input  logic [WORD-1:0]  h_CMASK,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DWORD-1:0] acc,
  output logic [4:0]       flags
);

  localparam int CW = $clog2(WORD);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_MUL, OP_CMP, OP_STORE, OP_ADDR
  } op_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [RW-1:0]     sel_q, sel_d;
  logic [WORD-1:0]   opnd_q, opnd_d;
  logic [WORD-1:0]   cmask_q, cmask_d;
  logic              phase_q, phase_d;
  logic              perm_q, perm_d;
  logic [DWORD-1:0]  acc_q, acc_d;
  logic              err_q, err_d, carry_q, carry_d, zero_q, zero_d;
  logic              gt_q, gt_d, eq_q, eq_d;
  logic [WORD-1:0]   regs_q [NREG];
  logic [WORD-1:0]   regs_d [NREG];
  logic [DWORD-1:0]  mcand_q, mcand_d, prod_q, prod_d;
  logic [WORD-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [7:0]        pmask_w;
  logic [DWORD-1:0]  opnd_ext;
  logic [WORD-1:0]   cmp_a, cmp_b;
  logic [DWORD:0]    sum_w;
  logic [DWORD-1:0]  prod_nx;

  assign pmask_w  = 8'(h_PMASK);
  assign opnd_ext = {{WORD{1'b0}}, opnd_q};
  assign cmp_a    = acc_q[WORD-1:0] & cmask_q;
  assign cmp_b    = opnd_q & cmask_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; EXEC spends one cycle registering the permission bit
  // before committing, so the ALU path never sees h_PMASK combinationally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_EXEC;
      S_EXEC: if (phase_q) state_d = (perm_q && op_q == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (cnt_q == CW'(WORD - 1)) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign acc   = acc_q;
  assign flags = {err_q, carry_q, zero_q, gt_q, eq_q};

  // NOTE: every *_d gets its hold value first so no path can infer a latch.
  always_comb begin
    op_d     = op_q;     sel_d   = sel_q;   opnd_d  = opnd_q;  cmask_d = cmask_q;
    phase_d  = phase_q;  perm_d  = perm_q;  acc_d   = acc_q;
    err_d    = err_q;    carry_d = carry_q; zero_d  = zero_q;
    gt_d     = gt_q;     eq_d    = eq_q;    regs_d  = regs_q;
    mcand_d  = mcand_q;  prod_d  = prod_q;  mplier_d = mplier_q; cnt_d = cnt_q;
    sum_w    = '0;
    prod_nx  = mplier_q[0] ? prod_q + mcand_q : prod_q;

    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d    = op;
        sel_d   = sel;
        opnd_d  = din & h_IMASK;
        cmask_d = h_CMASK;
        phase_d = 1'b0;
      end
      S_EXEC: if (!phase_q) begin
        perm_d  = pmask_w[op_q];
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (!perm_q) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
          case (op_q)
            OP_LOAD: begin acc_d = opnd_ext; zero_d = (opnd_ext == '0); end
            OP_ADD, OP_SUB, OP_ADDR: begin
              if (op_q == OP_SUB)      sum_w = {1'b0, acc_q} - {1'b0, opnd_ext};
              else if (op_q == OP_ADD) sum_w = {1'b0, acc_q} + {1'b0, opnd_ext};
              else sum_w = {1'b0, acc_q} + {1'b0, {WORD{1'b0}}, regs_q[sel_q]};
              acc_d   = sum_w[DWORD-1:0];
              carry_d = sum_w[DWORD];
              zero_d  = (sum_w[DWORD-1:0] == '0);
            end
            OP_AND: begin acc_d = acc_q & opnd_ext; zero_d = ((acc_q & opnd_ext) == '0); end
            OP_MUL: begin
              mcand_d  = {{WORD{1'b0}}, acc_q[WORD-1:0]};
              mplier_d = opnd_q;
              prod_d   = '0;
              cnt_d    = '0;
            end
            OP_CMP: begin eq_d = (cmp_a == cmp_b); gt_d = (cmp_a > cmp_b); end
            OP_STORE: regs_d[sel_q] = acc_q[WORD-1:0];
            default: ;
          endcase
        end
      end
      S_MUL: begin
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WORD - 1)) begin
          acc_d  = prod_nx;
          zero_d = (prod_nx == '0);
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0; sel_q <= '0; opnd_q <= '0; cmask_q <= '0;
      phase_q <= 1'b0; perm_q <= 1'b0; acc_q <= '0;
      err_q <= 1'b0; carry_q <= 1'b0; zero_q <= 1'b0; gt_q <= 1'b0; eq_q <= 1'b0;
      mcand_q <= '0; prod_q <= '0; mplier_q <= '0; cnt_q <= '0;
      // NOTE: the scratch file is built from flops, so it can and must be cleared on reset.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      op_q <= op_d; sel_q <= sel_d; opnd_q <= opnd_d; cmask_q <= cmask_d;
      phase_q <= phase_d; perm_q <= perm_d; acc_q <= acc_d;
      err_q <= err_d; carry_q <= carry_d; zero_q <= zero_d; gt_q <= gt_d; eq_q <= eq_d;
      mcand_q <= mcand_d; prod_q <= prod_d; mplier_q <= mplier_d; cnt_q <= cnt_d;
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_m_mask_alu_engine.sv
// Scoreboard bench for m_mask_alu_engine: directed vectors push expected
// results; an independent monitor checks latency and results on handshake.
module tb_m_mask_alu_engine;

  localparam logic [4:0] M_E = 5'b10000, M_C = 5'b01000, M_Z = 5'b00100, M_GE = 5'b00011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  op = '0;
  logic [1:0]  sel = '0;
  logic [7:0]  din = '0, h_IMASK = '0, h_PMASK = 8'hFF, h_CMASK = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] acc;
  logic [4:0]  flags;

  typedef struct {
    logic [15:0] acc;
    logic [4:0]  flags;
    logic [4:0]  mask;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0;
  int   edge_cnt = 0, acc_edge = 0;
  logic prev_ov = 1'b0;

  m_mask_alu_engine #(.WORD(8), .NREG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sel(sel), .din(din), .h_IMASK(h_IMASK), .h_PMASK(h_PMASK),
    .h_CMASK(h_CMASK), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency measured at out_valid rise, result compared at handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_edge = edge_cnt + 1;
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
        else check({sb[0].name, "_lat"}, edge_cnt - acc_edge, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_acc"}, 32'(acc), 32'(e.acc));
        check({e.name, "_flags"}, 32'(flags & e.mask), 32'(e.flags & e.mask));
      end
      prev_ov = out_valid;
    end
  end

  task automatic expect_res(input logic [15:0] a, input logic [4:0] f, input logic [4:0] m,
                            input int lat, input string name);
    exp_t e;
    e.acc = a; e.flags = f; e.mask = m; e.lat = lat; e.name = name;
    sb.push_back(e);
  endtask

  // Offer one instruction, then scramble every latched input after acceptance.
  task automatic drive(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d,
                       input logic [7:0] im, input logic [7:0] cm);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    op = o; sel = s; din = d; h_IMASK = im; h_CMASK = cm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; sel = ~s; din = ~d; h_IMASK = ~im; h_CMASK = ~cm;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (!in_ready) check({name, "_idle_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d,
                     input logic [7:0] im, input logic [7:0] cm, input logic [15:0] a,
                     input logic [4:0] f, input logic [4:0] m, input int lat, input string name);
    expect_res(a, f, m, lat, name);
    drive(o, s, d, im, cm);
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);

    //   op  sel din    imask  cmask  acc       flags     mask           lat name
    run(3'd0, 0, 8'hF3, 8'h0F, 8'hFF, 16'h0003, 5'b00000, M_E|M_Z,        2, "load_f3");
    run(3'd1, 0, 8'h01, 8'hFF, 8'hFF, 16'h0004, 5'b00000, M_E|M_C|M_Z,    2, "add_1");
    run(3'd0, 0, 8'h00, 8'hFF, 8'hFF, 16'h0000, 5'b00100, M_E|M_Z,        2, "load_0");
    run(3'd2, 0, 8'h01, 8'hFF, 8'hFF, 16'hFFFF, 5'b01000, M_E|M_C|M_Z,    2, "sub_1");
    run(3'd1, 0, 8'h01, 8'hFF, 8'hFF, 16'h0000, 5'b01100, M_E|M_C|M_Z,    2, "add_wrap");
    run(3'd0, 0, 8'hFF, 8'hFF, 8'hFF, 16'h00FF, 5'b00000, M_E|M_Z,        2, "load_ff");
    run(3'd4, 0, 8'hFF, 8'hFF, 8'hFF, 16'hFE01, 5'b00000, M_E|M_Z,       10, "mul_ff");
    h_PMASK = 8'hEF;
    run(3'd4, 0, 8'h03, 8'hFF, 8'hFF, 16'hFE01, 5'b10000, M_E|M_Z,        2, "mul_denied");
    h_PMASK = 8'hFF;
    run(3'd0, 0, 8'hA5, 8'hFF, 8'hFF, 16'h00A5, 5'b00000, M_E|M_Z,        2, "load_a5");
    run(3'd5, 0, 8'h35, 8'hFF, 8'h0F, 16'h00A5, 5'b00001, M_E|M_Z|M_GE,   2, "cmp_lo");
    run(3'd5, 0, 8'h35, 8'hFF, 8'hFF, 16'h00A5, 5'b00010, M_E|M_Z|M_GE,   2, "cmp_full");
    run(3'd6, 2, 8'h00, 8'hFF, 8'hFF, 16'h00A5, 5'b00010, M_E|M_Z|M_GE,   2, "store_r2");
    run(3'd0, 0, 8'h10, 8'hFF, 8'hFF, 16'h0010, 5'b00000, M_E|M_Z,        2, "load_10");
    run(3'd7, 2, 8'h00, 8'hFF, 8'hFF, 16'h00B5, 5'b00000, M_E|M_C|M_Z,    2, "addr_r2");
    run(3'd3, 0, 8'h0F, 8'hFF, 8'hFF, 16'h0005, 5'b00000, M_E|M_Z,        2, "and_0f");
    run(3'd3, 0, 8'h00, 8'hFF, 8'hFF, 16'h0000, 5'b00100, M_E|M_Z,        2, "and_00");
    run(3'd0, 0, 8'h03, 8'hFF, 8'hFF, 16'h0003, 5'b00000, M_E|M_Z,        2, "load_3");
    run(3'd4, 0, 8'h05, 8'hFF, 8'hFF, 16'h000F, 5'b00000, M_E|M_Z,       10, "mul_3x5");

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    expect_res(16'h005A, 5'b00000, M_E|M_Z, 2, "stall");
    drive(3'd0, 0, 8'h5A, 8'hFF, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_acc", 32'(acc), 32'h005A);
      check("stall_flags", 32'(flags & (M_E|M_Z)), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("stall");

    // Reset during the 4th MUL cycle aborts with no result.
    run(3'd0, 0, 8'h07, 8'hFF, 8'hFF, 16'h0007, 5'b00000, M_E|M_Z, 2, "load_7");
    drive(3'd4, 0, 8'h03, 8'hFF, 8'hFF);
    repeat (5) @(posedge clk);
    #1;
    check("mid_mul_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_acc", 32'(acc), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    // Scratch register 2 held A5 before reset; it must now read back as zero.
    run(3'd7, 2, 8'h00, 8'hFF, 8'hFF, 16'h0000, 5'b00100, M_E|M_C|M_Z, 2, "addr_after_rst");

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
